usr_serial_receiver: RTL
========================

Name: usr_serial_receiver

Overview:
Receive-side counterpart to the FSM-controlled universal shift register (USR) path. The block samples the serial bit stream that the USR shifts out and reassembles framed words: start bit, WIDTH data bits, optional even parity, stop bit. It presents each word on a valid/acknowledge hold interface to the downstream consumer and flags parity, framing and overrun errors.

Parameters:
WIDTH, 4, data bits per frame (matches the USR width)
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
sin  input  1  serial data from the USR shift-out bit
sin_en  input  1  bit strobe; sin is sampled only in cycles where sin_en=1
dir  input  1  0 = LSB-first, 1 = MSB-first; sampled with the start bit and held for the whole frame
rd_ack  input  1  consumer has taken data_out; honoured only while data_valid=1
data_out  output  WIDTH  last good received word
data_valid  output  1  data_out holds an unacknowledged word
parity_err  output  1  parity result for the word currently in data_out (1 = mismatch)
frame_err  output  1  one-cycle pulse when the stop bit is wrong
overrun  output  1  sticky; a completed frame was dropped because data_valid was still set
busy  output  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset: FSM goes to IDLE; bit_cnt=0; shift register=0. data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. Reset overrides every other input, including mid-frame; a partial frame is discarded.
- Cycles with sin_en=0 never change the FSM, bit_cnt or the shift register.
- Line idles at 0. Frame format: start=1, then WIDTH data bits, then the parity bit if PARITY_EN, then stop=0.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on sin_en=1 with sin=1, go to DATA, clear bit_cnt, latch dir. With sin_en=1 and sin=0, stay in IDLE.
- DATA, each strobe:
  - dir=0: right shift, with sin entering the MSB.
  - dir=1: left shift, with sin entering the LSB.
  - Increment bit_cnt.
  - On the WIDTH-th bit, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: on the strobe, compute perr = XOR of the data bits and sin (even parity, so 0 = good). Go to STOP. With PARITY_EN=0, perr=0.
- STOP, on the strobe:
  - sin=0: the frame is good. Go to IDLE and run the completion rules below.
  - sin=1: assert frame_err for exactly one cycle. Discard the frame, leave data_out and data_valid unchanged, and go to IDLE.
- Completion latency: outputs update on the clock edge that samples the stop bit, so they are visible in the next cycle.
- Completion rules:
  - data_valid=0: load data_out and parity_err, then set data_valid=1.
  - data_valid=1 and rd_ack=1 in the same cycle: load the new word and keep data_valid=1.
  - data_valid=1 and rd_ack=0: drop the new word, set overrun=1, keep the old data_out and parity_err.
- Acknowledge: rd_ack=1 with data_valid=1 and no completion in that cycle clears data_valid on the next edge. data_out holds its value. rd_ack while data_valid=0 is ignored.
- overrun clears only on reset.
- Back-to-back frames: a start bit is accepted on the first strobe after the return to IDLE; no idle bits are required.
- bit_cnt is $clog2(WIDTH+1) bits wide and never wraps within a frame.

Test Plan:
- Defaults, dir=0, continuous sin_en. Stream 1, 1,0,1,1, parity 1, stop 0 -> data_out=4'hD, data_valid=1 one cycle after the stop sample, parity_err=0, busy returns to 0.
- Same stream with parity bit 0 -> data_out=4'hD, data_valid=1, parity_err=1.
- Stop bit 1 -> frame_err high for exactly 1 cycle, data_valid stays 0, FSM back in IDLE. The next valid frame with data 4'h3 is then received correctly.
- Two good frames (4'hA, then 4'h5) with no rd_ack -> data_out=4'hA, overrun=1.
  - Pulse rd_ack -> data_valid=0, overrun still 1.
  - Completion and rd_ack in the same cycle -> new word loaded, data_valid stays 1.
- Assert reset after 2 data bits -> busy=0 and all outputs 0 next cycle. Then a full frame with 4'h9 -> data_out=4'h9.
- dir=1 with sin_en pulsing every 3rd cycle. Stream 1, 1,0,0,0, parity 1, stop 0 -> data_out=4'h8. No state change on non-strobe cycles.

Source files
------------

// File: rtl/usr_serial_receiver.sv
// Serial receiver for the universal shift register output stream.
// Reassembles framed words (start=1, WIDTH data bits, optional even parity,
// stop=0) sampled on sin_en strobes, and hands each good word to a consumer
// over a valid/acknowledge hold interface with parity, framing and overrun
// status.
module usr_serial_receiver #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             dir,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic [WIDTH-1:0] shift_q,      shift_d;
  logic             dir_q,        dir_d;
  logic             perr_q,       perr_d;
  logic             frame_err_q,  frame_err_d;
  logic [WIDTH-1:0] data_q,       data_d;
  logic             valid_q,      valid_d;
  logic             par_err_q,    par_err_d;
  logic             overrun_q,    overrun_d;

  // Set for the single cycle in which a frame with a correct stop bit ends.
  logic             frame_done;

  // Frame FSM and shift datapath: advances only on bit strobes.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    dir_d       = dir_q;
    perr_d      = perr_q;
    frame_err_d = 1'b0;
    frame_done  = 1'b0;

    if (sin_en) begin
      unique case (state_q)
        IDLE: begin
          if (sin) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            dir_d     = dir;
            perr_d    = 1'b0;
          end
        end

        DATA: begin
          if (!dir_q) begin
            // LSB-first: new bit enters at the MSB and walks right.
            shift_d[WIDTH-1] = sin;
            for (int i = 0; i < WIDTH - 1; i++) begin
              shift_d[i] = shift_q[i+1];
            end
          end else begin
            // MSB-first: new bit enters at the LSB and walks left.
            shift_d[0] = sin;
            for (int i = 1; i < WIDTH; i++) begin
              shift_d[i] = shift_q[i-1];
            end
          end
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end

        PARITY: begin
          // Even parity: XOR over data and parity bit is 0 for a good word.
          perr_d  = (^shift_q) ^ sin;
          state_d = STOP;
        end

        STOP: begin
          if (!sin) begin
            frame_done = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Consumer-side holding register: load, overrun and acknowledge handling.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    par_err_d = par_err_q;
    overrun_d = overrun_q;

    if (frame_done) begin
      if (!valid_q || rd_ack) begin
        data_d    = shift_q;
        par_err_d = perr_q;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rd_ack) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous reset; a partial frame is discarded.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      dir_q       <= 1'b0;
      perr_q      <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      dir_q       <= dir_d;
      perr_q      <= perr_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      par_err_q   <= par_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = par_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule
